// File: rtl/fpu_sgnj_pkg.sv
// Shared encodings and helpers for the FP sign-injection pipeline.
// Holds the format codes, operation bit indices, canonical NaNs and sign helpers.
package fpu_sgnj_pkg;

    typedef enum logic [1:0] {
        FMT_SP   = 2'b00,
        FMT_DP   = 2'b01,
        FMT_HP   = 2'b10,
        FMT_RSVD = 2'b11
    } fmt_e;

    localparam int OP_SGNJ  = 0;
    localparam int OP_SGNJN = 1;
    localparam int OP_SGNJX = 2;

    localparam logic [31:0] CANON_NAN_SP = 32'h7FC0_0000;
    localparam logic [15:0] CANON_NAN_HP = 16'h7E00;

    // Bit index of the sign for each format; reserved maps to 0 and is squashed later.
    function automatic logic [6:0] sign_pos(input fmt_e fmt);
        case (fmt)
            FMT_SP:  return 7'd31;
            FMT_DP:  return 7'd63;
            FMT_HP:  return 7'd15;
            default: return 7'd0;
        endcase
    endfunction

    // Fixed priority: SGNJ over SGNJN over SGNJX; no bit set clears the sign.
    function automatic logic sel_sign(input logic [2:0] op, input logic s1, input logic s2);
        if (op[OP_SGNJ])       return s2;
        else if (op[OP_SGNJN]) return ~s2;
        else if (op[OP_SGNJX]) return s1 ^ s2;
        else                   return 1'b0;
    endfunction

endpackage

// File: rtl/fp_sgnj_core.sv
// Combinational stage-0 datapath: format decode, sign selection and upper-bit box/fill.
// FPU_NANBOX_CHECK_EN enables NaN-box checking of SP/HP operands and boxing of results.
module fp_sgnj_core
    import fpu_sgnj_pkg::*;
#(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] in1,
    input  logic [FLEN-1:0] in2,
    input  logic [1:0]      fmt,
    input  logic [2:0]      operation,
    output logic [FLEN-1:0] result,
    output logic            illegal
);

`ifdef FPU_NANBOX_CHECK_EN
    localparam bit NANBOX_EN = 1'b1;
`else
    localparam bit NANBOX_EN = 1'b0;
`endif

    fmt_e            fmt_dec;
    logic [6:0]      pos;
    logic            narrow;
    logic [FLEN-1:0] fmt_mask;
    logic [FLEN-1:0] sign_mask;
    logic [FLEN-1:0] canon;
    logic [FLEN-1:0] a1;
    logic [FLEN-1:0] a2;
    logic            s1;
    logic            s2;
    logic            sign;

    // NOTE: every output of this block is assigned before any conditional use,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        fmt_dec = fmt_e'(fmt);
        illegal = (fmt_dec == FMT_RSVD) || ((fmt_dec == FMT_DP) && (FLEN < 64));
        pos     = sign_pos(fmt_dec);

        // A format narrower than FLEN has upper bits that need boxing or filling.
        narrow    = ((fmt_dec == FMT_SP) || (fmt_dec == FMT_HP)) && (int'(pos) + 1 < FLEN);
        fmt_mask  = narrow ? ((FLEN'(1) << (pos + 7'd1)) - FLEN'(1)) : '1;
        sign_mask = FLEN'(1) << pos;
        canon     = (fmt_dec == FMT_HP) ? FLEN'(CANON_NAN_HP) : FLEN'(CANON_NAN_SP);

        a1 = in1;
        a2 = in2;
        if (NANBOX_EN && narrow) begin
            if (!(&(in1 | fmt_mask))) a1 = canon;
            if (!(&(in2 | fmt_mask))) a2 = canon;
        end

        s1   = |(a1 & sign_mask);
        s2   = |(a2 & sign_mask);
        sign = sel_sign(operation, s1, s2);

        result = (a1 & fmt_mask & ~sign_mask) | (sign ? sign_mask : '0);
        if (NANBOX_EN && narrow) result = result | ~fmt_mask;
        if (illegal)             result = '0;
    end

endmodule

// File: rtl/fp_sign_inject_pipe.sv
// Valid/ready pipelined FP sign-injection unit: stage 0 computes, later stages only hold.
// Optional NaN-boxing is selected in fp_sgnj_core by FPU_NANBOX_CHECK_EN.
module fp_sign_inject_pipe
    import fpu_sgnj_pkg::*;
#(
    parameter int FLEN    = 64,
    parameter int LATENCY = 2,
    parameter int ID_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FLEN-1:0] input_1,
    input  logic [FLEN-1:0] input_2,
    input  logic [1:0]      fmt,
    input  logic [2:0]      operation,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] result,
    output logic [ID_W-1:0] out_id,
    output logic            out_illegal
);

    logic [FLEN-1:0]    core_data;
    logic               core_ill;

    logic [LATENCY-1:0] stg_valid;
    logic [FLEN-1:0]    stg_data [LATENCY];
    logic [ID_W-1:0]    stg_id   [LATENCY];
    logic [LATENCY-1:0] stg_ill;

    // rdy[k]: stage k may be written this cycle; rdy[LATENCY] is the downstream sink.
    logic [LATENCY:0]   rdy;
    logic [LATENCY-1:0] load_valid;
    logic [FLEN-1:0]    load_data [LATENCY];
    logic [ID_W-1:0]    load_id   [LATENCY];
    logic [LATENCY-1:0] load_ill;

    fp_sgnj_core #(.FLEN(FLEN)) u_core (
        .in1       (input_1),
        .in2       (input_2),
        .fmt       (fmt),
        .operation (operation),
        .result    (core_data),
        .illegal   (core_ill)
    );

    assign rdy[LATENCY] = out_ready;
    assign in_ready     = rdy[0] && !flush;

    for (genvar k = 0; k < LATENCY; k++) begin : g_chain
        assign rdy[k] = !stg_valid[k] || rdy[k+1];
        if (k == 0) begin : g_head
            assign load_valid[k] = in_valid && in_ready;
            assign load_data[k]  = core_data;
            assign load_id[k]    = in_id;
            assign load_ill[k]   = core_ill;
        end else begin : g_body
            assign load_valid[k] = stg_valid[k-1];
            assign load_data[k]  = stg_data[k-1];
            assign load_id[k]    = stg_id[k-1];
            assign load_ill[k]   = stg_ill[k-1];
        end
    end

    // NOTE: pipeline payload registers are reset as well as the valids, so the
    // outputs read zero out of reset rather than whatever the flops powered up as.
    // NOTE: all state here uses non-blocking assignment so every stage samples the
    // pre-edge value of its predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            stg_ill   <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                stg_data[k] <= '0;
                stg_id[k]   <= '0;
            end
        end else if (flush) begin
            stg_valid <= '0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                if (rdy[k]) begin
                    stg_valid[k] <= load_valid[k];
                    if (load_valid[k]) begin
                        stg_data[k] <= load_data[k];
                        stg_id[k]   <= load_id[k];
                        stg_ill[k]  <= load_ill[k];
                    end
                end
            end
        end
    end

    assign out_valid   = stg_valid[LATENCY-1];
    assign result      = stg_data[LATENCY-1];
    assign out_id      = stg_id[LATENCY-1];
    assign out_illegal = stg_ill[LATENCY-1];

endmodule
